// File: rtl/jtag_idcode_reader_if.sv
// Host-side bundle for the JTAG IDCODE reader: request/response handshake,
// captured result, and the 4-wire TAP link to the target.
interface jtag_idcode_reader_if #(
    parameter int IDCODE_LENGTH = 32
);
    logic                     start;
    logic                     busy;
    logic                     done;
    logic [IDCODE_LENGTH-1:0] idcode_out;
    logic                     id_match;
    logic                     id_err;
    logic                     jtag_tck;
    logic                     jtag_tms;
    logic                     jtag_tdi;
    logic                     jtag_tdo;

    // Environment side: issues start, observes results, and drives TDO back as the target.
    modport master (
        output start,
        output jtag_tdo,
        input  busy,
        input  done,
        input  idcode_out,
        input  id_match,
        input  id_err,
        input  jtag_tck,
        input  jtag_tms,
        input  jtag_tdi
    );

    // Reader side: accepts start, generates the TAP clock and control, and reports the result.
    modport slave (
        input  start,
        input  jtag_tdo,
        output busy,
        output done,
        output idcode_out,
        output id_match,
        output id_err,
        output jtag_tck,
        output jtag_tms,
        output jtag_tdi
    );
endinterface

// File: rtl/jtag_idcode_reader.sv
// JTAG IDCODE reader. On start it derives TCK from reg_clk, forces the target
// TAP through Test-Logic-Reset (which selects IDCODE), walks to Shift-DR,
// shifts IDCODE_LENGTH bits out of TDO LSB-first, and parks the TAP in
// Run-Test/Idle. Each TCK period is CLK_DIV cycles low then CLK_DIV high.
module jtag_idcode_reader #(
    parameter int                       IDCODE_LENGTH   = 32,
    parameter int                       CLK_DIV         = 2,
    parameter logic [IDCODE_LENGTH-1:0] EXPECTED_IDCODE = 32'hBA20A005
) (
    input  logic                 reg_clk,
    input  logic                 reg_rst,
    jtag_idcode_reader_if.slave  bus
);
    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int CNT_W = $clog2(IDCODE_LENGTH + 6);

    localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] SHIFT_LAST = CNT_W'(IDCODE_LENGTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TAP_RESET,
        S_TO_SHIFT,
        S_SHIFT,
        S_TO_IDLE,
        S_FINISH
    } state_t;

    state_t                   r_state;
    logic [DIV_W-1:0]         r_div;
    logic [CNT_W-1:0]         r_cnt;
    logic                     r_tck;
    logic                     r_tms;
    logic                     r_busy;
    logic                     r_done;
    logic [IDCODE_LENGTH-1:0] r_shift;
    logic [IDCODE_LENGTH-1:0] r_idcode;
    logic                     r_match;
    logic                     r_err;

    logic                     w_half_end;
    logic                     w_last_period;
    state_t                   w_next_state;
    logic [CNT_W-1:0]         w_next_cnt;
    logic                     w_next_tms;

    // TMS value for TCK period n of a walking state.
    function automatic logic tms_of(input state_t s, input logic [CNT_W-1:0] n);
        case (s)
            S_TAP_RESET: return 1'b1;
            S_TO_SHIFT:  return (n == CNT_W'(1));
            S_SHIFT:     return (n == SHIFT_LAST);
            S_TO_IDLE:   return (n == CNT_W'(0));
            default:     return 1'b0;
        endcase
    endfunction

    assign w_half_end = (r_div == DIV_LAST);

    // Decide where the next TCK period belongs and what TMS it carries.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned and no latch is inferred.
        w_last_period = 1'b0;
        w_next_state  = r_state;
        w_next_cnt    = r_cnt + 1'b1;
        case (r_state)
            S_TAP_RESET: w_last_period = (r_cnt == CNT_W'(4));
            S_TO_SHIFT:  w_last_period = (r_cnt == CNT_W'(3));
            S_SHIFT:     w_last_period = (r_cnt == SHIFT_LAST);
            S_TO_IDLE:   w_last_period = (r_cnt == CNT_W'(1));
            default:     w_last_period = 1'b0;
        endcase
        if (w_last_period) begin
            w_next_cnt = '0;
            case (r_state)
                S_TAP_RESET: w_next_state = S_TO_SHIFT;
                S_TO_SHIFT:  w_next_state = S_SHIFT;
                S_SHIFT:     w_next_state = S_TO_IDLE;
                S_TO_IDLE:   w_next_state = S_FINISH;
                default:     w_next_state = r_state;
            endcase
        end
        w_next_tms = tms_of(w_next_state, w_next_cnt);
    end

    // Transaction FSM with TCK divider, TDO capture and registered outputs.
    always_ff @(posedge reg_clk) begin
        // NOTE: non-blocking assignments throughout, so every flop sees the pre-edge values of the others.
        if (reg_rst) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_cnt    <= '0;
            r_tck    <= 1'b0;
            r_tms    <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_shift  <= '0;
            r_idcode <= '0;
            r_match  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_state <= S_TAP_RESET;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_div   <= '0;
                        r_tck   <= 1'b0;
                        r_tms   <= 1'b1;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    if (!w_half_end) begin
                        r_div <= r_div + 1'b1;
                    end else begin
                        r_div <= '0;
                        if (!r_tck) begin
                            // Rising TCK: TDO was launched on the previous falling edge and is stable now.
                            r_tck <= 1'b1;
                            if (r_state == S_SHIFT)
                                r_shift <= {bus.jtag_tdo, r_shift[IDCODE_LENGTH-1:1]};
                        end else begin
                            // Falling TCK ends the period; the next period's TMS is set on entry.
                            r_tck   <= 1'b0;
                            r_state <= w_next_state;
                            r_cnt   <= w_next_cnt;
                            r_tms   <= w_next_tms;
                            if (w_next_state == S_FINISH) begin
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                                r_idcode <= r_shift;
                                r_match  <= (r_shift == EXPECTED_IDCODE);
                                r_err    <= ~r_shift[0];
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.idcode_out = r_idcode;
    assign bus.id_match   = r_match;
    assign bus.id_err     = r_err;
    assign bus.jtag_tck   = r_tck;
    assign bus.jtag_tms   = r_tms;
    assign bus.jtag_tdi   = 1'b1;
endmodule

// File: tb/tb_jtag_idcode_reader.sv
// Bench for jtag_idcode_reader: a behavioural IEEE 1149.1 TAP target answers
// on the link, a table of directed reads plus randomized reads is applied,
// and results, done latency, TCK count and the TMS trace are checked.
module tb_jtag_idcode_reader;
    localparam int          LEN = 32;
    localparam int          DIV = 2;
    localparam logic [31:0] EXP = 32'hBA20A005;

    logic reg_clk = 1'b0;
    logic reg_rst = 1'b1;

    jtag_idcode_reader_if #(.IDCODE_LENGTH(LEN)) bus ();

    jtag_idcode_reader #(
        .IDCODE_LENGTH  (LEN),
        .CLK_DIV        (DIV),
        .EXPECTED_IDCODE(EXP)
    ) dut (
        .reg_clk(reg_clk),
        .reg_rst(reg_rst),
        .bus    (bus)
    );

    always #5 reg_clk = ~reg_clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural TAP target ----------------
    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR, UPD_DR,
        SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic tms);
        case (s)
            TLR:     return tms ? TLR    : RTI;
            RTI:     return tms ? SEL_DR : RTI;
            SEL_DR:  return tms ? SEL_IR : CAP_DR;
            CAP_DR:  return tms ? EX1_DR : SH_DR;
            SH_DR:   return tms ? EX1_DR : SH_DR;
            EX1_DR:  return tms ? UPD_DR : PAU_DR;
            PAU_DR:  return tms ? EX2_DR : PAU_DR;
            EX2_DR:  return tms ? UPD_DR : SH_DR;
            UPD_DR:  return tms ? SEL_DR : RTI;
            SEL_IR:  return tms ? TLR    : CAP_IR;
            CAP_IR:  return tms ? EX1_IR : SH_IR;
            SH_IR:   return tms ? EX1_IR : SH_IR;
            EX1_IR:  return tms ? UPD_IR : PAU_IR;
            PAU_IR:  return tms ? EX2_IR : PAU_IR;
            EX2_IR:  return tms ? UPD_IR : SH_IR;
            default: return tms ? SEL_DR : RTI;
        endcase
    endfunction

    tap_t        tap_state = SH_IR;   // arbitrary: the reader must re-synchronise it
    logic [31:0] tap_dr    = '0;
    logic [31:0] resp      = EXP;
    logic        tdo_r     = 1'b1;
    logic        tie0      = 1'b0;
    logic        tms_q[$];
    int          tck_rises = 0;
    int          tdi_bad   = 0;

    assign bus.jtag_tdo = tie0 ? 1'b0 : tdo_r;

    // Target samples TMS/TDI on rising TCK; records the trace.
    always @(posedge bus.jtag_tck) begin
        tms_q.push_back(bus.jtag_tms);
        tck_rises <= tck_rises + 1;
        if (bus.jtag_tdi !== 1'b1) tdi_bad <= tdi_bad + 1;
        if (tap_state == CAP_DR) tap_dr <= resp;
        else if (tap_state == SH_DR) tap_dr <= {bus.jtag_tdi, tap_dr[31:1]};
        tap_state <= tap_next(tap_state, bus.jtag_tms);
    end

    // Target launches TDO on falling TCK.
    always @(negedge bus.jtag_tck) begin
        if (tap_state == SH_DR) tdo_r <= tap_dr[0];
    end

    // ---------------- reference expectations ----------------
    function automatic int model_done_cycle();
        return 1 + (5 + 4 + LEN + 2) * 2 * DIV;
    endfunction

    task automatic check_tms_trace(input string tag);
        logic exp_q[$];
        int   errs;
        exp_q = {};
        for (int i = 0; i < 5; i++) exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b1);
        exp_q.push_back(1'b0); exp_q.push_back(1'b0);
        for (int i = 0; i < LEN - 1; i++) exp_q.push_back(1'b0);
        exp_q.push_back(1'b1);
        exp_q.push_back(1'b1); exp_q.push_back(1'b0);
        errs = (tms_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < exp_q.size() && i < tms_q.size(); i++)
            if (tms_q[i] !== exp_q[i]) errs++;
        check({tag, ".tms_trace_errs"}, errs, 0);
    endtask

    // One read: start at the next negedge (cycle 0), optional spurious start at
    // cycle `spur`, optional start poke in the done cycle. Returns in the done cycle
    // (or one cycle later when poking).
    task automatic do_read(input string tag, input logic [31:0] val, input logic tie,
                           input int spur, input int exp_done, input logic [31:0] exp_id,
                           input logic exp_m, input logic exp_e, input bit poke);
        int done_at;
        int busy_bad;
        resp = val;
        tie0 = tie;
        @(negedge reg_clk);
        tms_q = {};
        tck_rises = 0;
        tdi_bad = 0;
        bus.start = 1'b1;
        done_at = -1;
        busy_bad = 0;
        for (int k = 1; k <= exp_done + 200; k++) begin
            @(negedge reg_clk);
            bus.start = (k == spur);
            if (bus.done === 1'b1) begin
                done_at = k;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad++;
        end
        bus.start = 1'b0;
        check({tag, ".done_cycle"}, done_at, exp_done);
        check({tag, ".busy_low_wait"}, busy_bad, 0);
        check({tag, ".busy_at_done"}, bus.busy, 1'b0);
        check({tag, ".idcode_out"}, bus.idcode_out, exp_id);
        check({tag, ".id_match"}, bus.id_match, exp_m);
        check({tag, ".id_err"}, bus.id_err, exp_e);
        check({tag, ".tck_rises"}, tck_rises, 5 + 4 + LEN + 2);
        check({tag, ".tdi_low_count"}, tdi_bad, 0);
        check({tag, ".tap_state"}, tap_state, RTI);
        check_tms_trace(tag);
        if (poke) begin
            bus.start = 1'b1;
            @(negedge reg_clk);
            bus.start = 1'b0;
            check({tag, ".start_in_finish_busy"}, bus.busy, 1'b0);
            check({tag, ".idle_tck"}, bus.jtag_tck, 1'b0);
            check({tag, ".idle_tms"}, bus.jtag_tms, 1'b0);
        end
    endtask

    typedef struct {
        string       name;
        logic [31:0] val;
        logic        tie;
        int          spur;
        int          exp_done;
        logic [31:0] exp_id;
        logic        exp_m;
        logic        exp_e;
        bit          poke;
    } vec_t;

    vec_t vecs[4];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"match",   32'hBA20A005, 1'b0, 50, 173, 32'hBA20A005, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{"other",   32'h12345677, 1'b0, -1, 173, 32'h12345677, 1'b0, 1'b0, 1'b1};
        vecs[2] = '{"tdo0",    32'hDEADBEEF, 1'b1, -1, 173, 32'h00000000, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{"bypass",  32'hBA20A004, 1'b0, -1, 173, 32'hBA20A004, 1'b0, 1'b1, 1'b0};

        bus.start = 1'b0;
        reg_rst = 1'b1;
        repeat (3) @(negedge reg_clk);
        check("rst.busy", bus.busy, 1'b0);
        check("rst.done", bus.done, 1'b0);
        check("rst.idcode_out", bus.idcode_out, 32'h0);
        check("rst.id_match", bus.id_match, 1'b0);
        check("rst.id_err", bus.id_err, 1'b0);
        check("rst.tck", bus.jtag_tck, 1'b0);
        check("rst.tms", bus.jtag_tms, 1'b1);
        check("rst.tdi", bus.jtag_tdi, 1'b1);
        reg_rst = 1'b0;

        check("model.done_cycle", model_done_cycle(), 173);

        // Directed table; consecutive entries start the cycle after the previous done.
        for (int i = 0; i < 4; i++)
            do_read(vecs[i].name, vecs[i].val, vecs[i].tie, vecs[i].spur, vecs[i].exp_done,
                    vecs[i].exp_id, vecs[i].exp_m, vecs[i].exp_e, vecs[i].poke);

        // Abort with reset at cycle 100 of a read; idcode_out holds a prior nonzero value.
        resp = EXP;
        tie0 = 1'b0;
        @(negedge reg_clk);
        bus.start = 1'b1;
        @(negedge reg_clk);
        bus.start = 1'b0;
        repeat (99) @(negedge reg_clk);
        reg_rst = 1'b1;
        @(negedge reg_clk);
        reg_rst = 1'b0;
        check("abort.busy", bus.busy, 1'b0);
        check("abort.done", bus.done, 1'b0);
        check("abort.tck", bus.jtag_tck, 1'b0);
        check("abort.tms", bus.jtag_tms, 1'b1);
        check("abort.idcode_out", bus.idcode_out, 32'h0);
        do_read("after_abort", EXP, 1'b0, -1, model_done_cycle(), EXP, 1'b1, 1'b0, 1'b0);

        // Randomized reads against the reference expectations.
        for (int i = 0; i < 8; i++) begin
            logic [31:0] v;
            int          sp;
            v = (i == 0) ? EXP : $urandom;
            if ($urandom_range(3) == 0) v[0] = 1'b0;
            sp = ($urandom_range(1) == 0) ? -1 : int'($urandom_range(2, 170));
            do_read($sformatf("rand%0d", i), v, 1'b0, sp, model_done_cycle(),
                    v, (v == EXP), ~v[0], 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
